id_stage_pipe: RTL and testbench

Pipelined RV32I instruction-decode stage, successor to the single-cycle decode block. It holds the register file, control decode and immediate generator, and adds:
- an IF/ID valid/ready input handshake
- a registered ID/EX output with back-pressure
- load-use hazard stall with bubble insertion
- flush
- parametrised data width and register count
It sits between the fetch stage and the execute stage.

---
 rtl/id_stage_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - pipelined RV32I decode stage with register file and ID/EX register
//
// Optional feature macro: WB_BYPASS_EN (write-back to read-port bypass).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   IF/ID handshake; in_instr, in_pc carry the instruction
//   wb_en/wb_rd/wb_data register-file write port
//   flush               kill the held instruction and the incoming one
//   out_valid/out_ready ID/EX handshake with back-pressure
//   out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd,
//   out_ctrl, out_illegal  registered decode results
//   stall               load-use hazard active this cycle
module id_stage_pipe #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [8:0]      out_ctrl,
   output logic            out_illegal,
   output logic            stall
);

   localparam int AW = $clog2(NUM_REGS);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // ---------------------------------------------------------------- register file
   logic [XLEN-1:0] rf_q [NUM_REGS];

   // x0 and indices beyond the implemented register count are not storage.
   function automatic logic idx_live(input logic [4:0] idx);
      return (idx != 5'd0) && (int'(idx) < NUM_REGS);
   endfunction

   function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
      logic [XLEN-1:0] r;
      r = '0;
      if (idx_live(idx)) begin
`ifdef WB_BYPASS_EN
         if (wb_en && (wb_rd == idx)) r = wb_data;
         else                         r = rf_q[idx[AW-1:0]];
`else
         r = rf_q[idx[AW-1:0]];
`endif
      end
      return r;
   endfunction

   // Writes are independent of stall, flush and back-pressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else if (wb_en && idx_live(wb_rd)) begin
         rf_q[wb_rd[AW-1:0]] <= wb_data;
      end
   end

   // ---------------------------------------------------------------- decode
   logic [6:0]        opcode;
   logic [8:0]        ctrl_d;
   logic              illegal_d;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]   imm_d;
   logic [XLEN-1:0]   rs1_data_d;
   logic [XLEN-1:0]   rs2_data_d;

   assign opcode = in_instr[6:0];

   // ctrl: 0 RegWrite, 1 ALUSrc, 2 MemWrite, 3 MemRead, 4 ResultSrc, 5 Branch, 7:6 ALUOp, 8 Jump
   always_comb begin
      ctrl_d    = '0;
      illegal_d = 1'b0;
      imm32     = '0;
      unique case (opcode)
         OP_R: ctrl_d = 9'h081;
         OP_I_ALU: begin
            ctrl_d = 9'h083;
            imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OP_LOAD: begin
            ctrl_d = 9'h01B;
            imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OP_STORE: begin
            ctrl_d = 9'h006;
            imm32  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OP_BRANCH: begin
            ctrl_d = 9'h060;
            imm32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            ctrl_d = 9'h003;
            imm32  = {in_instr[31:12], 12'd0};
         end
         OP_JAL: begin
            ctrl_d = 9'h101;
            imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
         end
         OP_JALR: begin
            ctrl_d = 9'h103;
            imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         default: illegal_d = 1'b1;
      endcase
   end

   // Signed source widens with sign extension when XLEN is 64.
   assign imm_d      = XLEN'(imm32);
   assign rs1_data_d = rf_read(in_instr[19:15]);
   assign rs2_data_d = rf_read(in_instr[24:20]);

   // ---------------------------------------------------------------- ID/EX register
   logic            valid_q;
   logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
   logic [4:0]      rs1_q, rs2_q, rd_q;
   logic [8:0]      ctrl_q;
   logic            illegal_q;
   logic            adv;
   logic            hazard;

   assign adv    = !valid_q || out_ready;
   // A load in ID/EX whose destination feeds the incoming instruction.
   assign hazard = in_valid && valid_q && ctrl_q[3] && (rd_q != 5'd0) &&
                   ((rd_q == in_instr[19:15]) || (rd_q == in_instr[24:20]));

   assign stall    = hazard && !flush;
   assign in_ready = rst && (flush || (adv && !hazard));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         ctrl_q     <= '0;
         illegal_q  <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (adv && hazard) begin
         valid_q <= 1'b0;
      end else if (adv && in_valid) begin
         valid_q    <= 1'b1;
         pc_q       <= in_pc;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_q      <= in_instr[19:15];
         rs2_q      <= in_instr[24:20];
         rd_q       <= in_instr[11:7];
         ctrl_q     <= ctrl_d;
         illegal_q  <= illegal_d;
      end else if (adv) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = pc_q;
   assign out_rs1_data = rs1_data_q;
   assign out_rs2_data = rs2_data_q;
   assign out_imm      = imm_q;
   assign out_rs1      = rs1_q;
   assign out_rs2      = rs2_q;
   assign out_rd       = rd_q;
   assign out_ctrl     = ctrl_q;
   assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed self-checking bench for id_stage_pipe
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_ready;

   logic        in_ready, out_valid, out_illegal, stall;
   logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [8:0]  out_ctrl;

   logic        e_in_ready, e_out_valid, e_out_illegal, e_stall;
   logic [31:0] e_out_pc, e_out_rs1_data, e_out_rs2_data, e_out_imm;
   logic [4:0]  e_out_rs1, e_out_rs2, e_out_rd;
   logic [8:0]  e_out_ctrl;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_stage_pipe #(.XLEN(32), .NUM_REGS(32)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_rs1_data(out_rs1_data),
      .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rs1(out_rs1),
      .out_rs2(out_rs2), .out_rd(out_rd), .out_ctrl(out_ctrl),
      .out_illegal(out_illegal), .stall(stall)
   );

   id_stage_pipe #(.XLEN(32), .NUM_REGS(16)) u_dut_e (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush), .out_valid(e_out_valid),
      .out_ready(out_ready), .out_pc(e_out_pc), .out_rs1_data(e_out_rs1_data),
      .out_rs2_data(e_out_rs2_data), .out_imm(e_out_imm), .out_rs1(e_out_rs1),
      .out_rs2(e_out_rs2), .out_rd(e_out_rd), .out_ctrl(e_out_ctrl),
      .out_illegal(e_out_illegal), .stall(e_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [31:0] instr, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
   endtask

   logic [31:0] dec_instr [5];
   logic [8:0]  dec_ctrl  [5];
   logic [31:0] dec_imm   [5];
   logic        dec_ill   [5];
   logic [31:0] exp_bypass;

   initial begin
      dec_instr[0] = 32'hFFFFFFFF; dec_ctrl[0] = 9'h000; dec_imm[0] = 32'h0;        dec_ill[0] = 1'b1;
      dec_instr[1] = 32'hFE112E23; dec_ctrl[1] = 9'h006; dec_imm[1] = 32'hFFFFFFFC; dec_ill[1] = 1'b0;
      dec_instr[2] = 32'hFE000CE3; dec_ctrl[2] = 9'h060; dec_imm[2] = 32'hFFFFFFF8; dec_ill[2] = 1'b0;
      dec_instr[3] = 32'h001000EF; dec_ctrl[3] = 9'h101; dec_imm[3] = 32'h00000800; dec_ill[3] = 1'b0;
      dec_instr[4] = 32'h123452B7; dec_ctrl[4] = 9'h003; dec_imm[4] = 32'h12345000; dec_ill[4] = 1'b0;
`ifdef WB_BYPASS_EN
      exp_bypass = 32'hDEADBEEF;
`else
      exp_bypass = 32'h0;
`endif

      rst = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0;
      wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      chk("rst_stall",     {31'd0, stall}, 32'd0);
      chk("rst_out_ctrl",  {23'd0, out_ctrl}, 32'd0);
      chk("rst_out_pc",    out_pc, 32'd0);
      rst = 1'b1;

      // write-back to x5 in the same cycle ADD x6,x5,x0 is decoded
      drv(32'h00028333, 32'h200);
      wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      #1 chk("a_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("a_valid", {31'd0, out_valid}, 32'd1);
      chk("a_rs1_data", out_rs1_data, exp_bypass);
      chk("a_rd", {27'd0, out_rd}, 32'd6);
      chk("a_ctrl", {23'd0, out_ctrl}, 32'h081);
      chk("a_imm", out_imm, 32'd0);

      // ADDI x1,x0,5 while x1 <= 0x11
      drv(32'h00500093, 32'h100);
      wb_rd = 5'd1; wb_data = 32'h11;
      tick();
      wb_en = 1'b0;
      chk("b_valid", {31'd0, out_valid}, 32'd1);
      chk("b_rd", {27'd0, out_rd}, 32'd1);
      chk("b_imm", out_imm, 32'd5);
      chk("b_ctrl", {23'd0, out_ctrl}, 32'h083);
      chk("b_pc", out_pc, 32'h100);
      chk("b_rs1_data", out_rs1_data, 32'd0);

      // ADD x7,x5,x0 sees the committed x5
      drv(32'h000283B3, 32'h104);
      tick();
      chk("c_rs1_data", out_rs1_data, 32'hDEADBEEF);
      chk("c_rs2_data", out_rs2_data, 32'd0);

      // LW x2,0(x1) then ADD x3,x2,x1: one stall cycle, bubble, then issue
      drv(32'h0000A103, 32'h108);
      tick();
      chk("d_ld_ctrl", {23'd0, out_ctrl}, 32'h01B);
      chk("d_ld_rs1_data", out_rs1_data, 32'h11);
      drv(32'h001101B3, 32'h10C);
      wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h22;
      #1 chk("d_stall", {31'd0, stall}, 32'd1);
      chk("d_stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      wb_en = 1'b0;
      chk("d_bubble", {31'd0, out_valid}, 32'd0);
      chk("d_stall_clear", {31'd0, stall}, 32'd0);
      chk("d_retry_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("d_add_valid", {31'd0, out_valid}, 32'd1);
      chk("d_add_rd", {27'd0, out_rd}, 32'd3);
      chk("d_add_rs1", {27'd0, out_rs1}, 32'd2);
      chk("d_add_rs2", {27'd0, out_rs2}, 32'd1);
      chk("d_add_rs1_data", out_rs1_data, 32'h22);
      chk("d_add_rs2_data", out_rs2_data, 32'h11);
      chk("d_add_pc", out_pc, 32'h10C);

      // back-pressure for 3 cycles
      drv(32'h00500093, 32'h110);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("e_in_ready_held", {31'd0, in_ready}, 32'd0);
         tick();
         chk("e_valid_held", {31'd0, out_valid}, 32'd1);
         chk("e_pc_held", out_pc, 32'h10C);
         chk("e_rd_held", {27'd0, out_rd}, 32'd3);
         chk("e_rs1_data_held", out_rs1_data, 32'h22);
      end
      out_ready = 1'b1;
      #1 chk("e_in_ready_resume", {31'd0, in_ready}, 32'd1);
      tick();
      chk("e_pc_next", out_pc, 32'h110);
      chk("e_imm_next", out_imm, 32'd5);

      // flush with valid held and incoming instruction
      drv(32'h000283B3, 32'h114);
      flush = 1'b1;
      #1 chk("f_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      flush = 1'b0;
      chk("f_valid", {31'd0, out_valid}, 32'd0);

      // flush masks a load-use hazard
      drv(32'h0000A103, 32'h118);
      tick();
      drv(32'h001101B3, 32'h11C);
      flush = 1'b1;
      #1 chk("g_flush_stall", {31'd0, stall}, 32'd0);
      chk("g_flush_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      flush = 1'b0;
      chk("g_valid", {31'd0, out_valid}, 32'd0);

      // decode table: illegal, store, branch, JAL, LUI
      for (int i = 0; i < 5; i++) begin
         drv(dec_instr[i], 32'h200 + 32'(i * 4));
         tick();
         chk("dec_valid", {31'd0, out_valid}, 32'd1);
         chk("dec_ctrl", {23'd0, out_ctrl}, {23'd0, dec_ctrl[i]});
         chk("dec_illegal", {31'd0, out_illegal}, {31'd0, dec_ill[i]});
         if (!dec_ill[i]) chk("dec_imm", out_imm, dec_imm[i]);
      end

      // write to x0 ignored; idle input drains the stage
      in_valid = 1'b0;
      wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
      tick();
      wb_en = 1'b0;
      chk("h_idle_valid", {31'd0, out_valid}, 32'd0);
      drv(32'h00000333, 32'h300);
      tick();
      chk("h_x0_read", out_rs1_data, 32'd0);

      // x20 exists only in the 32-register build
      in_valid = 1'b0;
      wb_en = 1'b1; wb_rd = 5'd20; wb_data = 32'h77;
      tick();
      wb_en = 1'b0;
      drv(32'h000A0433, 32'h304);
      tick();
      chk("i_x20_rv32i", out_rs1_data, 32'h77);
      chk("i_x20_rv32e", e_out_rs1_data, 32'd0);
      chk("i_rv32e_valid", {31'd0, e_out_valid}, 32'd1);

      in_valid = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
